// File: rtl/transfer_sequencer.sv
// transfer_sequencer: accepts one transfer command at a time and sequences the
// mux selects, shared load enable and bus-driver select of a two-register file.
// The register not being written recirculates its own value so the shared load
// enable leaves it unchanged.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   cmd_valid       command present
//   cmd_op[2:0]     0 NOP, 1 LOAD_A, 2 LOAD_B, 3 LOAD_AB, 4 A_TO_B, 5 B_TO_A, 6/7 illegal
//   cmd_ready       high only in IDLE
//   sel_a, sel_b    file mux selects (0 = external data, 1 = BUS)
//   enable          shared register load enable
//   oe_a            1 = A drives BUS, 0 = B drives BUS
//   busy            high outside IDLE
//   done, err       one-cycle completion / illegal-opcode pulses
//   xfer_count      completed load cycles, wraps
module transfer_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd_op,
  output logic             cmd_ready,
  output logic             sel_a,
  output logic             sel_b,
  output logic             enable,
  output logic             oe_a,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] xfer_count
);

  localparam int unsigned SETTLE_W = 4;
  localparam logic [2:0]  OP_LAST_LOAD = 3'd5;

  typedef enum logic [1:0] {IDLE, SETUP, EXEC, DONE} state_t;

  state_t              state, state_d;
  logic [SETTLE_W-1:0] settle, settle_d;
  logic [2:0]          op_q, op_d;
  logic [2:0]          pat;
  logic                cmd_ready_d, sel_a_d, sel_b_d, enable_d, oe_a_d;
  logic                busy_d, done_d, err_d;
  logic [CNT_W-1:0]    count_d;

  // Drive pattern {sel_a, sel_b, oe_a} for each load opcode.
  function automatic logic [2:0] drive_pattern(input logic [2:0] op);
    case (op)
      3'd1:    drive_pattern = 3'b010;  // LOAD_A, B recirculates
      3'd2:    drive_pattern = 3'b101;  // LOAD_B, A recirculates
      3'd3:    drive_pattern = 3'b001;  // LOAD_AB
      3'd4:    drive_pattern = 3'b111;  // A_TO_B, A reloads itself
      3'd5:    drive_pattern = 3'b110;  // B_TO_A, B reloads itself
      default: drive_pattern = 3'b111;
    endcase
  endfunction

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle     <= '0;
      op_q       <= '0;
      cmd_ready  <= 1'b1;
      sel_a      <= 1'b1;
      sel_b      <= 1'b1;
      enable     <= 1'b0;
      oe_a       <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      xfer_count <= '0;
    end else begin
      state      <= state_d;
      settle     <= settle_d;
      op_q       <= op_d;
      cmd_ready  <= cmd_ready_d;
      sel_a      <= sel_a_d;
      sel_b      <= sel_b_d;
      enable     <= enable_d;
      oe_a       <= oe_a_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      xfer_count <= count_d;
    end
  end

  // Next state and next values of the registered outputs.
  always_comb begin
    state_d  = state;
    settle_d = settle;
    op_d     = op_q;
    pat      = drive_pattern(op_q);
    sel_a_d  = 1'b1;
    sel_b_d  = 1'b1;
    oe_a_d   = oe_a;
    enable_d = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    count_d  = xfer_count;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d = cmd_op;
          if ((cmd_op != 3'd0) && (cmd_op <= OP_LAST_LOAD)) begin
            state_d                    = SETUP;
            settle_d                   = SETTLE_W'(SETTLE_CYCLES - 1);
            {sel_a_d, sel_b_d, oe_a_d} = drive_pattern(cmd_op);
          end else begin
            // NOP and illegal opcodes finish without touching the file.
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = (cmd_op > OP_LAST_LOAD);
          end
        end
      end
      SETUP: begin
        {sel_a_d, sel_b_d, oe_a_d} = pat;
        if (settle == '0) begin
          state_d  = EXEC;
          enable_d = 1'b1;
        end else begin
          settle_d = settle - SETTLE_W'(1);
        end
      end
      EXEC: begin
        // File loads at the end of this cycle; selects return to BUS after.
        state_d = DONE;
        done_d  = 1'b1;
        count_d = xfer_count + CNT_W'(1);
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

endmodule

// File: doc/transfer_sequencer.md
# transfer_sequencer

Command-driven control sequencer that sits directly upstream of the two-register file (registers A and B on a shared tri-state bus). It accepts one transfer command at a time over a valid/ready handshake and drives the file's mux selects, shared load enable and bus-driver select. Because both registers share one load enable, it keeps the idle register unchanged by routing the non-target register's own value back to itself. It reports completion, illegal opcodes and a running transfer count.

## Interface
- SETTLE_CYCLES, 1, cycles the drive pattern is held with enable low before the load cycle (legal 1..15)
- CNT_W, 8, width of the transfer counter
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_op  in  3  opcode: 0 NOP, 1 LOAD_A, 2 LOAD_B, 3 LOAD_AB, 4 A_TO_B, 5 B_TO_A, 6/7 illegal
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready
- sel_a  out  1  mux A select to file: 0 = DA, 1 = BUS
- sel_b  out  1  mux B select to file: 0 = DB, 1 = BUS
- enable  out  1  shared register load enable to file
- oe_a  out  1  1 = A drives BUS, 0 = B drives BUS (file derives B's enable as ~oe_a)
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a command finishes (including NOP and illegal)
- err  out  1  one-cycle pulse, coincident with done, for illegal opcode
- xfer_count  out  CNT_W  number of completed load cycles, wraps modulo 2^CNT_W

## Operation
- States: IDLE, SETUP, EXEC, DONE. All outputs registered.
- IDLE: cmd_ready=1, enable=0, sel_a=1, sel_b=1, oe_a holds last value. Accept latches cmd_op.
- Accept of op 1-5 -> SETUP; op 0 -> DONE (done=1, err=0); op 6/7 -> DONE (done=1, err=1). No enable pulse for 0/6/7.
- Drive pattern (sel_a, sel_b, oe_a), held through SETUP and EXEC:
  - LOAD_A: 0,1,0 (B recirculates via BUS)
  - LOAD_B: 1,0,1 (A recirculates via BUS)
  - LOAD_AB: 0,0,1
  - A_TO_B: 1,1,1 (A reloads itself)
  - B_TO_A: 1,1,0 (B reloads itself)
- SETUP: enable=0 for exactly SETTLE_CYCLES cycles (internal down-counter), then EXEC.
- EXEC: enable=1 for exactly one cycle; xfer_count += 1; then DONE.
- DONE: enable=0, done=1 one cycle, sel_a/sel_b return to 1, oe_a unchanged; then IDLE.
- cmd_valid outside IDLE is ignored; cmd_op is sampled only at accept.
- xfer_count wraps from 2^CNT_W-1 to 0 without flag.

## Timing
- Reset (rst high at an edge): state IDLE, sel_a=1, sel_b=1, oe_a=1, enable=0, done=0, err=0, busy=0, xfer_count=0, settle counter 0. Reset mid-command aborts it: no enable pulse, no done.
- A command sampled in the same cycle as rst is dropped.
- Accept at edge T: SETUP during T+1..T+SETTLE_CYCLES, EXEC (enable=1) in cycle T+SETTLE_CYCLES+1, register file loads at the end of that cycle, done in T+SETTLE_CYCLES+2, cmd_ready high again in T+SETTLE_CYCLES+3.
- Throughput: one load command per SETTLE_CYCLES+3 cycles; NOP/illegal: one per 2 cycles (accept, DONE).
- oe_a changes only on the edge entering SETUP, never coincident with enable=1.
- Back-to-back cmd_valid held high: next command accepted in the first IDLE cycle.

## Test plan
- Reset, SETTLE_CYCLES=1: after rst, outputs sel_a=1, sel_b=1, oe_a=1, enable=0, cmd_ready=1, xfer_count=0.
- LOAD_A with DA=8'h5A, B preloaded 8'hC3: enable high exactly one cycle at accept+2, done at accept+3; file A=8'h5A, B=8'hC3, xfer_count=1.
- A_TO_B then B_TO_A with A=8'h11, B=8'h22 held cmd_valid: B=8'h11 after first, A=8'h11 after second; oe_a transitions 1->0 only during SETUP; xfer_count=2.
- cmd_op=6: done and err pulse together one cycle after accept, enable never high, xfer_count unchanged; NOP: done without err.
- SETTLE_CYCLES=3: enable asserted at accept+4, done at accept+5; rst asserted at accept+2 -> no enable pulse, no done, xfer_count=0.
- CNT_W=2: five LOAD_AB commands -> xfer_count sequence 1,2,3,0,1.
